instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Multi-cycle fetch and next-PC stage directly upstream of the main control decoder.
- Owns the program counter, fetches 32-bit instructions over a req/ready handshake, and presents the instruction to decode. The opcode is instr[31:26].
- Consumes the 2-bit branch code the control decoder produces for the current instruction. On instruction completion it selects the next PC: sequential, conditional branch, jump, or call with link.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- HALT_OPCODE, 6'b111111, opcode that stops fetching

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, held until accepted
- imem_addr  out  ADDR_W  fetch address, always equal to pc
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- imem_ready  in  1  memory accepts the request and returns data this cycle
- instr  out  32  registered current instruction
- instr_valid  out  1  instr is held for decode/execute
- ex_done  in  1  single-cycle pulse: datapath finished the current instruction
- branch  in  2  from control: 00 none, 01 conditional, 10 jump, 11 call
- cond_flag  in  1  ALU branch condition, sampled with ex_done
- pc  out  ADDR_W  current program counter
- link_addr  out  ADDR_W  registered return address for call
- link_we  out  1  one-cycle pulse: write link_addr to the link register
- halted  out  1  HALT_OPCODE fetched

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=FETCH, pc=RESET_PC, instr=0, link_addr=0.
  - instr_valid=0, link_we=0, halted=0.
  - imem_req is low while rst_n=0, including when reset arrives mid-fetch or mid-execute. No partial update survives reset.
- FSM states: FETCH, EXEC, HALT.
- FETCH:
  - imem_req=1; imem_addr=pc.
  - Zero-wait memory is legal: if imem_ready=1 in the first cycle of FETCH, capture on that edge.
  - On imem_ready=1:
    - If imem_rdata[31:26]==HALT_OPCODE: state goes to HALT and halted goes to 1. instr_valid stays 0; instr is still captured.
    - Otherwise: instr<=imem_rdata, instr_valid<=1, state goes to EXEC.
  - ex_done is ignored in FETCH.
- EXEC:
  - imem_req=0; instr and instr_valid are held stable.
  - When ex_done=1, sample branch and cond_flag and define seq = pc+4.
  - Next PC by branch code:
    - 00: next=seq.
    - 01: next = cond_flag ? seq + (sext(instr[15:0])<<2) : seq.
    - 10: next = seq + (sext(instr[25:0])<<2).
    - 11: next as for 10; additionally link_addr<=seq and link_we=1 for exactly that cycle.
  - Then: pc<=next, instr_valid<=0, state goes to FETCH.
  - Minimum fetch-to-fetch spacing is 2 cycles.
- HALT: imem_req=0 and halted=1 until reset; all inputs ignored.
- Arithmetic:
  - All PC sums are modulo 2^ADDR_W. Wrap-around is silent; no flag.
  - Offsets are sign-extended to ADDR_W before the shift.
  - pc[1:0] is always 00, because targets are word-aligned by construction.
- pc changes only on the ex_done edge or on reset.
- link_we is never asserted outside EXEC.

Decomposition:
- Shared package (cpu_pkg):
  - branch code constants BR_NONE=2'b00, BR_COND=2'b01, BR_JUMP=2'b10, BR_CALL=2'b11.
  - fetch FSM state enum (FETCH, EXEC, HALT).
  - HALT_OPCODE and opcode field bounds [31:26].
- One sub-module: next_pc_calc, the combinational next-PC and sign-extension logic. The FSM and registers stay in the top module.

Test Plan:
- Reset/sequential:
  - Stimulus: release rst_n, memory with 1-cycle wait returns 32'h0000_0000 at addr 0, then ex_done with branch=00.
  - Required: imem_req high at addr 0; instr_valid=1 after capture; pc=4 after ex_done; next request at addr 4.
- Conditional branch:
  - Stimulus: pc=0x10, instr[15:0]=16'hFFFE, branch=01.
  - Required: cond_flag=1 gives pc=0x0C; cond_flag=0 gives pc=0x14.
- Call:
  - Stimulus: pc=0x20, instr[25:0]=26'd4, branch=11.
  - Required: pc=0x34; link_addr=0x24; link_we high for exactly 1 cycle.
- Halt:
  - Stimulus: fetch returns opcode 6'b111111.
  - Required: halted=1 and instr_valid=0; imem_req stays 0 for 20 cycles despite ex_done pulses.
- Wrap/zero-wait/ignored pulse:
  - Stimulus: pc=0xFFFF_FFFC with branch=00; zero-wait memory; a spurious ex_done during FETCH.
  - Required: pc=0x0000_0000; capture happens in the first FETCH cycle; the spurious ex_done causes no PC change.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during a pending FETCH with imem_ready=0; repeat during EXEC.
  - Required: imem_req drops immediately; pc=RESET_PC; instr_valid=0; the FSM restarts in FETCH.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: branch codes, fetch FSM states and
// opcode field helpers used by the fetch unit and its next-PC logic.
package cpu_pkg;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [1:0] BR_JUMP = 2'b10;
    localparam logic [1:0] BR_CALL = 2'b11;

    localparam logic [5:0] HALT_OPCODE_DFLT = 6'b111111;
    localparam int         OPC_HI           = 31;
    localparam int         OPC_LO           = 26;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch unit (master) and
// the instruction memory (slave).
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, conditional branch, jump/call.
// Offsets are word offsets, sign-extended before scaling; sums wrap mod 2^ADDR_W.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [25:0]       offset_field,
    input  logic [1:0]        branch,
    input  logic              cond_flag,
    output logic [ADDR_W-1:0] seq_pc,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] off_short;
    logic [ADDR_W-1:0] off_long;

    // Scaling by 4 is folded into the concatenation to keep widths exact.
    assign off_short = {{(ADDR_W-18){offset_field[15]}}, offset_field[15:0], 2'b00};
    assign off_long  = {{(ADDR_W-28){offset_field[25]}}, offset_field[25:0], 2'b00};
    assign seq_pc    = pc + ADDR_W'(4);

    always_comb begin
        next_pc = seq_pc;
        unique case (branch)
            BR_NONE: next_pc = seq_pc;
            BR_COND: next_pc = cond_flag ? (seq_pc + off_short) : seq_pc;
            BR_JUMP: next_pc = seq_pc + off_long;
            BR_CALL: next_pc = seq_pc + off_long;
            default: next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch / next-PC stage: owns the PC, fetches over req/ready, holds the
// instruction for decode and retires it on ex_done with branch/call handling.
//
// state | meaning
// FETCH | request outstanding at pc, waiting for imem_ready
// EXEC  | instr held for decode/execute, waiting for ex_done
// HALT  | halt opcode fetched, idle until reset
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DFLT
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  imem,
    output logic [31:0]         instr,
    output logic                instr_valid,
    input  logic                ex_done,
    input  logic [1:0]          branch,
    input  logic                cond_flag,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   link_addr,
    output logic                link_we,
    output logic                halted
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic              capture;
    logic              is_halt;
    logic              retire;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] next_pc;

    assign capture = (state == FETCH) && imem.imem_ready;
    assign is_halt = (opcode_of(imem.imem_rdata) == HALT_OPCODE);
    assign retire  = (state == EXEC) && ex_done;

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .pc           (pc),
        .offset_field (instr[25:0]),
        .branch       (branch),
        .cond_flag    (cond_flag),
        .seq_pc       (seq_pc),
        .next_pc      (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH: begin
                if (capture) begin
                    state_nxt = is_halt ? HALT : EXEC;
                end
            end
            EXEC: begin
                if (ex_done) begin
                    state_nxt = FETCH;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    // Request and link strobe are gated by rst_n so they drop the instant
    // reset asserts, even though the state register resets to FETCH.
    always_comb begin
        imem.imem_req  = rst_n && (state == FETCH);
        imem.imem_addr = pc;
        halted         = (state == HALT);
        link_we        = rst_n && retire && (branch == BR_CALL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= ADDR_W'(RESET_PC);
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            link_addr   <= '0;
        end else begin
            if (capture) begin
                instr       <= imem.imem_rdata;
                instr_valid <= !is_halt;
            end
            if (retire) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
                if (branch == BR_CALL) begin
                    link_addr <= seq_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential flow, branches, call/link,
// wrap-around, zero-wait fetch, resets mid-operation and halt.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        ex_done;
    logic [1:0]  branch;
    logic        cond_flag;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        link_we;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit_if #(.ADDR_W(32)) imem ();

    instr_fetch_unit #(
        .ADDR_W      (32),
        .RESET_PC    (32'h0000_0000),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem),
        .instr       (instr),
        .instr_valid (instr_valid),
        .ex_done     (ex_done),
        .branch      (branch),
        .cond_flag   (cond_flag),
        .pc          (pc),
        .link_addr   (link_addr),
        .link_we     (link_we),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in FETCH; returns at the negedge after capture.
    task automatic fetch_word(input logic [31:0] word, input int waits);
        imem.imem_ready = 1'b0;
        for (int i = 0; i < waits; i++) @(negedge clk);
        imem.imem_ready = 1'b1;
        imem.imem_rdata = word;
        @(negedge clk);
        imem.imem_ready = 1'b0;
    endtask

    // Called at a negedge in EXEC; returns at the negedge after retire.
    task automatic retire(input logic [1:0] br, input logic cf);
        ex_done   = 1'b1;
        branch    = br;
        cond_flag = cf;
        @(negedge clk);
        ex_done   = 1'b0;
        branch    = BR_NONE;
        cond_flag = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        ex_done         = 1'b0;
        branch          = BR_NONE;
        cond_flag       = 1'b0;
        imem.imem_ready = 1'b0;
        imem.imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req",   32'(imem.imem_req), 32'd0);
        chk("rst_pc",    pc, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halt",  32'(halted), 32'd0);
        chk("rst_lwe",   32'(link_we), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_link",  link_addr, 32'h0);

        // Sequential fetch with one wait cycle
        rst_n = 1'b1;
        @(negedge clk);
        chk("seq_req",  32'(imem.imem_req), 32'd1);
        chk("seq_addr", imem.imem_addr, 32'h0);
        fetch_word(32'h0000_0000, 1);
        chk("seq_valid",   32'(instr_valid), 32'd1);
        chk("seq_req_off", 32'(imem.imem_req), 32'd0);
        chk("seq_lwe_off", 32'(link_we), 32'd0);
        retire(BR_NONE, 1'b0);
        chk("seq_pc",     pc, 32'h4);
        chk("seq_valid0", 32'(instr_valid), 32'd0);
        chk("seq_addr4",  imem.imem_addr, 32'h4);
        chk("seq_req4",   32'(imem.imem_req), 32'd1);

        for (int i = 0; i < 3; i++) begin
            fetch_word(32'h0000_0000, 0);
            retire(BR_NONE, 1'b0);
        end
        chk("pc_0x10", pc, 32'h10);

        // Conditional branch taken: 0x14 + (-2 << 2) = 0x0C
        fetch_word(32'h0000_FFFE, 1);
        retire(BR_COND, 1'b1);
        chk("cond_taken", pc, 32'h0C);
        fetch_word(32'h0000_0000, 0);
        retire(BR_NONE, 1'b0);
        chk("pc_0x10b", pc, 32'h10);
        fetch_word(32'h0000_FFFE, 2);
        retire(BR_COND, 1'b0);
        chk("cond_not_taken", pc, 32'h14);

        for (int i = 0; i < 3; i++) begin
            fetch_word(32'h0000_0000, 0);
            retire(BR_NONE, 1'b0);
        end
        chk("pc_0x20", pc, 32'h20);

        // Call: 0x24 + (4 << 2) = 0x34, link 0x24
        fetch_word(32'h0000_0004, 1);
        ex_done   = 1'b1;
        branch    = BR_CALL;
        cond_flag = 1'b0;
        #1;
        chk("call_lwe_hi", 32'(link_we), 32'd1);
        @(negedge clk);
        ex_done = 1'b0;
        branch  = BR_NONE;
        chk("call_lwe_lo", 32'(link_we), 32'd0);
        chk("call_pc",     pc, 32'h34);
        chk("call_link",   link_addr, 32'h24);
        @(negedge clk);
        chk("call_lwe_lo2", 32'(link_we), 32'd0);

        // Jump backward: 0x38 + (-15 << 2) = 0xFFFF_FFFC
        fetch_word(32'h0BFF_FFF1, 0);
        retire(BR_JUMP, 1'b0);
        chk("jump_pc", pc, 32'hFFFF_FFFC);

        // Zero-wait capture with a spurious ex_done in the same FETCH cycle
        imem.imem_ready = 1'b1;
        imem.imem_rdata = 32'h0000_0008;
        ex_done         = 1'b1;
        branch          = BR_JUMP;
        cond_flag       = 1'b1;
        @(negedge clk);
        imem.imem_ready = 1'b0;
        ex_done         = 1'b0;
        branch          = BR_NONE;
        cond_flag       = 1'b0;
        chk("zw_valid",    32'(instr_valid), 32'd1);
        chk("zw_instr",    instr, 32'h0000_0008);
        chk("spurious_pc", pc, 32'hFFFF_FFFC);
        retire(BR_NONE, 1'b0);
        chk("wrap_pc", pc, 32'h0);

        // Reset during a pending fetch
        fetch_word(32'h0000_0000, 0);
        retire(BR_NONE, 1'b0);
        chk("pre_rst_pc", pc, 32'h4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstf_req", 32'(imem.imem_req), 32'd0);
        chk("rstf_pc",  pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstf_restart", 32'(imem.imem_req), 32'd1);

        // Reset during execute
        fetch_word(32'h1234_5678, 1);
        chk("pre_rste_valid", 32'(instr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rste_valid", 32'(instr_valid), 32'd0);
        chk("rste_instr", instr, 32'h0);
        chk("rste_req",   32'(imem.imem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rste_restart", 32'(imem.imem_req), 32'd1);
        chk("rste_addr",    imem.imem_addr, 32'h0);

        // Halt opcode
        fetch_word(32'hFC00_0000, 1);
        chk("halt_flag",  32'(halted), 32'd1);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_instr", instr, 32'hFC00_0000);
        for (int i = 0; i < 20; i++) begin
            ex_done         = i[0];
            branch          = BR_CALL;
            imem.imem_ready = 1'b1;
            #1;
            chk("halt_lwe", 32'(link_we), 32'd0);
            @(negedge clk);
            chk("halt_req",  32'(imem.imem_req), 32'd0);
            chk("halt_pc",   pc, 32'h0);
            chk("halt_hold", 32'(halted), 32'd1);
        end
        ex_done         = 1'b0;
        imem.imem_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
